// File: rtl/spi_ram_master.sv
// SPI mode-0 master for the SPI-slave/RAM pair: shifts out {op, data} command frames
// and, for read-data commands, clocks the RAM word back in after a turnaround gap.
module spi_ram_master #(
    parameter int WORD_SIZE  = 8,
    parameter int CLK_DIV    = 2,
    parameter int TURNAROUND = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [WORD_SIZE-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic                 SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int FW   = WORD_SIZE + 2;
    localparam int BMAX = (FW > TURNAROUND) ? FW : TURNAROUND;
    localparam int BW   = $clog2(BMAX);
    localparam int GW   = $clog2(2 * CLK_DIV);

    localparam logic [GW-1:0] HALF_LD = GW'(CLK_DIV - 1);
    // GAP plus the mandatory IDLE accept cycle together give 2*CLK_DIV deselect cycles
    localparam logic [GW-1:0] GAP_LD  = GW'(2 * CLK_DIV - 2);
    localparam logic [BW-1:0] TX_LD   = BW'(FW - 1);
    localparam logic [BW-1:0] TURN_LD = BW'(TURNAROUND - 1);
    localparam logic [BW-1:0] RX_LD   = BW'(WORD_SIZE - 1);

    typedef enum logic [2:0] {IDLE, TX, TURN, RX, GAP} state_t;

    state_t               state;
    logic [FW-1:0]        frame;
    logic [WORD_SIZE-1:0] rx_sh;
    logic [GW-1:0]        hcnt;
    logic [GW-1:0]        gcnt;
    logic [BW-1:0]        bcnt;
    logic                 is_read;
    logic                 tick;
    logic                 sclk_rise;
    logic                 sclk_fall;

    assign tick      = (hcnt == '0);
    assign sclk_rise = tick & ~SCLK;
    assign sclk_fall = tick & SCLK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            SS_n      <= 1'b1;
            SCLK      <= 1'b0;
            MOSI      <= 1'b0;
            frame     <= '0;
            rx_sh     <= '0;
            hcnt      <= '0;
            gcnt      <= '0;
            bcnt      <= '0;
            is_read   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            if (state == TX || state == TURN || state == RX) begin
                if (tick) begin
                    hcnt <= HALF_LD;
                    SCLK <= ~SCLK;
                end else begin
                    hcnt <= hcnt - 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        frame     <= {cmd_op, cmd_data};
                        MOSI      <= cmd_op[1];
                        SS_n      <= 1'b0;
                        hcnt      <= HALF_LD;
                        bcnt      <= TX_LD;
                        is_read   <= (cmd_op == 2'b11);
                        cmd_ready <= 1'b0;
                        state     <= TX;
                    end
                end
                TX: begin
                    if (sclk_fall) begin
                        if (bcnt == '0) begin
                            MOSI <= 1'b0;
                            if (is_read) begin
                                bcnt  <= TURN_LD;
                                state <= TURN;
                            end else begin
                                SS_n  <= 1'b1;
                                gcnt  <= GAP_LD;
                                state <= GAP;
                            end
                        end else begin
                            frame <= {frame[FW-2:0], 1'b0};
                            MOSI  <= frame[FW-2];
                            bcnt  <= bcnt - 1'b1;
                        end
                    end
                end
                TURN: begin
                    if (sclk_fall) begin
                        if (bcnt == '0) begin
                            bcnt  <= RX_LD;
                            state <= RX;
                        end else begin
                            bcnt <= bcnt - 1'b1;
                        end
                    end
                end
                RX: begin
                    if (sclk_rise) begin
                        rx_sh <= {rx_sh[WORD_SIZE-2:0], MISO};
                    end
                    if (sclk_fall) begin
                        if (bcnt == '0) begin
                            rsp_data  <= rx_sh;
                            rsp_valid <= 1'b1;
                            SS_n      <= 1'b1;
                            gcnt      <= GAP_LD;
                            state     <= GAP;
                        end else begin
                            bcnt <= bcnt - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gcnt == '0) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    SS_n      <= 1'b1;
                    SCLK      <= 1'b0;
                    MOSI      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: SPI slave + RAM model on the default instance, a
// CLK_DIV=1/TURNAROUND=1 instance for fast-clock reads, and frame/response scoreboards.
module tb_spi_ram_master;

    localparam int CD  = 2;
    localparam int TA  = 2;
    localparam int TA1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       cmd_valid, cmd_ready, rsp_valid, ss_n, sclk, mosi, miso;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data, rsp_data;

    logic       cmd_valid1, cmd_ready1, rsp_valid1, ss_n1, sclk1, mosi1, miso1;
    logic [1:0] cmd_op1;
    logic [7:0] cmd_data1, rsp_data1;

    spi_ram_master #(.WORD_SIZE(8), .CLK_DIV(CD), .TURNAROUND(TA)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    spi_ram_master #(.WORD_SIZE(8), .CLK_DIV(1), .TURNAROUND(TA1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op1), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .SS_n(ss_n1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1)
    );

    typedef struct {
        logic [9:0] frame;
        int         len;
    } frm_t;

    frm_t       exp_frames[$];
    logic [7:0] exp_rsp[$];
    bit   [7:0] sh_ram[256];
    bit   [7:0] sh_wa, sh_ra;
    bit   [7:0] sl_ram[256];
    bit   [7:0] sl_wa, sl_ra;

    int checks = 0;
    int errors = 0;
    int frames_done = 0, aborted = 0, rsp_seen = 0, rsp1_seen = 0;
    int last_gap = -1, last_e0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave + RAM model, default instance; sampled on the falling clk edge
    bit         prev_ss = 1'b1, prev_sclk = 1'b0;
    int         nrise = 0, low_start = 0, high_start = 0, ss_rise_cyc = -1000;
    logic [9:0] rxb = '0;
    logic [7:0] word = '0;
    initial miso = 1'b0;

    always @(negedge clk) begin
        frm_t f;
        if (prev_ss && ss_n === 1'b0) begin
            nrise     = 0;
            rxb       = '0;
            low_start = cyc;
            last_gap  = cyc - high_start;
            word      = sl_ram[sl_ra];
            miso      = 1'b0;
        end else if (!prev_ss && ss_n === 1'b1) begin
            ss_rise_cyc = cyc;
            high_start  = cyc;
            miso        = 1'b0;
            if ((nrise == 10 && rxb[9:8] != 2'b11) || (nrise == 18 + TA && rxb[9:8] == 2'b11)) begin
                frames_done++;
                case (rxb[9:8])
                    2'b00:   sl_wa = rxb[7:0];
                    2'b01:   sl_ram[sl_wa] = rxb[7:0];
                    2'b10:   sl_ra = rxb[7:0];
                    default: ;
                endcase
                check("frame_expected", exp_frames.size() > 0, 1);
                if (exp_frames.size() > 0) begin
                    f = exp_frames.pop_front();
                    check("frame_bits", rxb, f.frame);
                    check("ss_low_len", cyc - low_start, f.len);
                end
            end else begin
                aborted++;
            end
        end else if (ss_n === 1'b0) begin
            if (!prev_sclk && sclk === 1'b1) begin
                if (nrise < 10) rxb = {rxb[8:0], mosi};
                nrise++;
            end else if (prev_sclk && sclk === 1'b0) begin
                miso = (nrise >= 10 + TA && nrise < 18 + TA) ? word[7 - (nrise - 10 - TA)] : 1'b0;
            end
        end
        if (rsp_valid === 1'b1) begin
            rsp_seen++;
            check("rsp_after_ss_rise", cyc - ss_rise_cyc, 0);
            check("rsp_expected", exp_rsp.size() > 0, 1);
            if (exp_rsp.size() > 0) check("rsp_data", rsp_data, exp_rsp.pop_front());
        end
        prev_ss   = (ss_n === 1'b1);
        prev_sclk = (sclk === 1'b1);
    end

    // Slave for the fast instance: always returns 0x5A
    bit         prev_ss1 = 1'b1, prev_sclk1 = 1'b0;
    int         nrise1 = 0, low1 = 0, toggles1 = 0, first_t1 = 0, last_t1 = 0;
    logic [9:0] rxb1 = '0;
    logic [7:0] word1 = 8'h5A;
    initial miso1 = 1'b0;

    always @(negedge clk) begin
        if (prev_ss1 && ss_n1 === 1'b0) begin
            nrise1   = 0;
            rxb1     = '0;
            low1     = cyc;
            toggles1 = 0;
        end else if (!prev_ss1 && ss_n1 === 1'b1) begin
            miso1 = 1'b0;
            check("u1_ss_low_len", cyc - low1, 38);
            check("u1_sclk_toggles", toggles1, 37);
            check("u1_toggle_span", last_t1 - first_t1, 36);
            check("u1_frame_bits", rxb1, 10'h300);
        end else if (ss_n1 === 1'b0) begin
            if ((sclk1 === 1'b1) != prev_sclk1) begin
                if (toggles1 == 0) first_t1 = cyc;
                last_t1 = cyc;
                toggles1++;
            end
            if (!prev_sclk1 && sclk1 === 1'b1) begin
                if (nrise1 < 10) rxb1 = {rxb1[8:0], mosi1};
                nrise1++;
            end else if (prev_sclk1 && sclk1 === 1'b0) begin
                miso1 = (nrise1 >= 10 + TA1 && nrise1 < 18 + TA1) ? word1[7 - (nrise1 - 10 - TA1)] : 1'b0;
            end
        end
        if (rsp_valid1 === 1'b1) begin
            rsp1_seen++;
            check("u1_rsp_data", rsp_data1, 8'h5A);
        end
        prev_ss1   = (ss_n1 === 1'b1);
        prev_sclk1 = (sclk1 === 1'b1);
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input bit hold, input bit expect_it);
        int   n;
        frm_t f;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        if (expect_it) begin
            f.frame = {op, d};
            f.len   = (op == 2'b11) ? (36 + 2 * TA) * CD : 20 * CD;
            exp_frames.push_back(f);
            case (op)
                2'b00:   sh_wa = d;
                2'b01:   sh_ram[sh_wa] = d;
                2'b10:   sh_ra = d;
                default: exp_rsp.push_back(sh_ram[sh_ra]);
            endcase
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait_bound", n < 2000, 1);
        last_e0 = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_until(input int t);
        int n;
        n = 0;
        while (cyc < t && n < 10000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e_prev, fd0, rs0, ab0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_data   = 8'h00;
        cmd_valid1 = 1'b0;
        cmd_op1    = 2'b00;
        cmd_data1  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_ss_n", ss_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write-address command, ready timing
        issue(2'b00, 8'h3C, 0, 1);
        e = last_e0;
        wait_until(e + 42);
        check("cmd_ready_in_gap", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_return", cmd_ready, 1);

        // Full sequence, back-to-back with cmd_valid held high
        fd0 = frames_done;
        rs0 = rsp_seen;
        issue(2'b00, 8'h10, 1, 1);
        e_prev = last_e0;
        issue(2'b01, 8'hA5, 1, 1);
        check("b2b_accept_1", last_e0 - e_prev, 44);
        e_prev = last_e0;
        issue(2'b10, 8'h10, 1, 1);
        check("b2b_accept_2", last_e0 - e_prev, 44);
        e_prev = last_e0;
        check("no_rsp_before_read", rsp_seen - rs0, 0);
        issue(2'b11, 8'h00, 0, 1);
        check("b2b_accept_3", last_e0 - e_prev, 44);
        @(negedge clk);
        check("b2b_ss_gap", last_gap, 4);
        wait_until(last_e0 + 120);
        check("seq_frames", frames_done - fd0, 4);
        check("seq_rsp_pulses", rsp_seen - rs0, 1);
        check("seq_rsp_held", rsp_data, 8'hA5);

        // Command-bus activity while busy must not disturb the frame in flight
        fd0 = frames_done;
        rs0 = rsp_seen;
        issue(2'b11, 8'h00, 0, 1);
        e = last_e0;
        wait_until(e + 10);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 8'hFF;
        check("busy_ready_low", cmd_ready, 0);
        wait_until(e + 60);
        cmd_op   = 2'b00;
        cmd_data = 8'h77;
        wait_until(e + 70);
        cmd_valid = 1'b0;
        wait_until(e + 130);
        check("busy_frames", frames_done - fd0, 1);
        check("busy_rsp_pulses", rsp_seen - rs0, 1);

        // Reset in the middle of RX after three MISO bits
        rs0 = rsp_seen;
        ab0 = aborted;
        issue(2'b11, 8'h00, 0, 0);
        e = last_e0;
        wait_until(e + 60);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ss_n", ss_n, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_aborted", aborted - ab0, 1);
        check("midrst_no_rsp", rsp_seen - rs0, 0);
        issue(2'b10, 8'h10, 0, 1);
        issue(2'b11, 8'h00, 0, 1);
        wait_until(last_e0 + 120);
        check("post_rst_rsp", rsp_data, 8'hA5);

        // CLK_DIV=1, TURNAROUND=1 read
        cmd_valid1 = 1'b1;
        cmd_op1    = 2'b11;
        cmd_data1  = 8'h00;
        check("u1_ready", cmd_ready1, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid1 = 1'b0;
        e = cyc;
        wait_until(e + 60);
        check("u1_rsp_pulses", rsp1_seen, 1);
        check("u1_rsp_held", rsp_data1, 8'h5A);

        check("frames_left", exp_frames.size(), 0);
        check("rsp_left", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
